instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- IF stage plus IF/ID pipeline register of the 32-bit pipelined CPU.
- Drives the instruction-memory address and holds the PC.
- Presents `instruction_id` and `flush_id` to the instruction decoder, which consumes them directly.
- Applies stall requests from the hazard unit, taken-branch redirects from EX, and instruction-memory wait states. Each of these holds the stage or inserts a bubble.

Parameters:
- PC_W, 16, program counter / instruction-memory address width.
- RESET_PC, 0, PC value loaded on reset.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset: synchronous, active-high (1 = reset); name kept for codebase consistency.
- imem_addr  out  PC_W  instruction-memory address; equals `pc`.
- imem_data  in  INSTR_W  instruction word, valid when `imem_rdy`=1 in the same cycle.
- imem_rdy  in  1  memory returned `imem_data` this cycle.
- stall  in  1  hazard unit: hold IF and IF/ID.
- br_taken  in  1  EX: branch/jump taken this cycle.
- br_target  in  PC_W  EX: redirect address.
- instruction_id  out  INSTR_W  IF/ID instruction to the decoder.
- pc_id  out  PC_W  PC+1 of `instruction_id`, for branch-target arithmetic downstream.
- flush_id  out  1  1 = `instruction_id` is a bubble; the decoder forces all controls to 0.
- fetch_state  out  2  current FSM state, for debug.

Behaviour:
- Reset (`rst_n`=1 at a clock edge), all registered:
  - `pc`=RESET_PC, `instruction_id`=0, `pc_id`=0, `flush_id`=1, state=BOOT.
  - Reset mid-operation discards everything, including a simultaneous `br_taken`.
- FSM states: BOOT(0), RUN(1), MISS(2), REDIR(3).
- Per-edge priority: `rst_n` > `br_taken` > `stall` > `imem_rdy`=0 > normal fetch.
- `br_taken`=1, any state, even with `stall`=1:
  - `pc`<=`br_target`, `instruction_id`<=0, `flush_id`<=1, state<=REDIR.
  - The wrong-path IF/ID word is always killed.
- `stall`=1, no `br_taken`:
  - `pc`, `instruction_id`, `pc_id`, `flush_id` and state all hold.
  - `imem_data` is ignored even if `imem_rdy`=1.
- `imem_rdy`=0, no `stall`, no `br_taken`:
  - `pc` holds, `flush_id`<=1, `instruction_id`<=0, state<=MISS.
- Normal fetch (`imem_rdy`=1):
  - `instruction_id`<=`imem_data`, `pc_id`<=`pc`+1, `flush_id`<=0, `pc`<=`pc`+1, state<=RUN.
- BOOT and REDIR last one cycle. Each exits by the normal/miss rules above, so the first valid IF/ID word appears at the earliest one edge after reset release or redirect.
- Latency: instruction at address A fetched on edge N appears on `instruction_id` after edge N; `pc_id`=A+1.
- Arithmetic: PC increment is modulo 2^PC_W. 2^PC_W-1 wraps to 0, with no flag.
- `imem_addr` is combinational from the `pc` register only; no input-to-`imem_addr` path.
- Throughput: one instruction per cycle in RUN with no stall or miss.

Optional Feature:
- Macro: IF_PERF_CNT_EN.
- Defined, adds outputs:
  - `perf_fetched` [31:0]: increments on every normal fetch.
  - `perf_bubbles` [31:0]: increments on every edge that loads `flush_id`<=1, excluding reset.
  - Both reset to 0, saturate at 2^32-1, and hold during `stall`.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package `cpu_pkg`:
  - fetch-state encoding (BOOT/RUN/MISS/REDIR).
  - INSTR_W.
  - `NOP_INSTR` = 0, which matches the decoder's all-zero no-op opcode.
- One natural sub-module: `if_id_reg`, the IF/ID register with hold/bubble/load controls.
- PC register and FSM stay in the top.

Test Plan:
- Reset then `imem_rdy`=1, memory word = 0x80000000|addr, RESET_PC=0:
  - After reset release, the first edge gives `instruction_id`=0x80000000, `pc_id`=1, `flush_id`=0.
  - Next edge gives 0x80000001, `pc_id`=2.
- Stall for 3 cycles at `pc`=5:
  - `imem_addr` stays 5; `instruction_id`, `pc_id` and `flush_id` unchanged for 3 edges.
  - Resumes with the word at 5.
- `br_taken`=1, `br_target`=0x0040, asserted together with `stall`=1:
  - Next edge: `pc`=0x0040, `flush_id`=1, `instruction_id`=0, state=REDIR.
  - Following edge: word at 0x0040 with `pc_id`=0x0041.
- `imem_rdy`=0 for 2 cycles at `pc`=9:
  - 2 bubbles (`flush_id`=1), state=MISS, `pc` stays 9.
  - Then fetch of 9 with `pc_id`=10.
- Wrap, PC_W=4, `pc`=15, normal fetch:
  - `pc_id`=0 and next `imem_addr`=0.
- `rst_n`=1 asserted together with `br_taken`=1 in RUN:
  - Next edge `pc`=RESET_PC, state=BOOT, `flush_id`=1.
  - With IF_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU package: fetch-state encoding, instruction width, no-op word and IF/ID control encoding.
package cpu_pkg;

  localparam int unsigned INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR = '0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_MISS  = 2'd2,
    ST_REDIR = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    IFID_HOLD   = 2'd0,
    IFID_BUBBLE = 2'd1,
    IFID_LOAD   = 2'd2
  } ifid_op_e;

endpackage

// File: rtl/instr_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: hold, insert a bubble (no-op + flush), or load a fetched word.
module if_id_reg #(
  parameter int unsigned INSTR_W = 32,
  parameter int unsigned PC_W    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         op,
  input  logic [INSTR_W-1:0] instr_in,
  input  logic [PC_W-1:0]    pc_in,
  output logic [INSTR_W-1:0] instr_out,
  output logic [PC_W-1:0]    pc_out,
  output logic               flush_out
);
  import cpu_pkg::*;

  logic [INSTR_W-1:0] instr_d, instr_q;
  logic [PC_W-1:0]    pc_d, pc_q;
  logic               flush_d, flush_q;

  // A bubble keeps pc_q; only the instruction word and flush flag are forced.
  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    flush_d = flush_q;
    case (op)
      IFID_BUBBLE: begin
        instr_d = INSTR_W'(NOP_INSTR);
        flush_d = 1'b1;
      end
      IFID_LOAD: begin
        instr_d = instr_in;
        pc_d    = pc_in;
        flush_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      instr_q <= INSTR_W'(NOP_INSTR);
      pc_q    <= '0;
      flush_q <= 1'b1;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      flush_q <= flush_d;
    end
  end

  assign instr_out = instr_q;
  assign pc_out    = pc_q;
  assign flush_out = flush_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// IF stage with PC register, fetch FSM and IF/ID register.
// Optional IF_PERF_CNT_EN adds saturating fetch/bubble counters.
module instr_fetch_stage #(
  parameter int unsigned PC_W     = 16,
  parameter int unsigned RESET_PC = 0,
  parameter int unsigned INSTR_W  = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               imem_rdy,
  input  logic               stall,
  input  logic               br_taken,
  input  logic [PC_W-1:0]    br_target,
  output logic [INSTR_W-1:0] instruction_id,
  output logic [PC_W-1:0]    pc_id,
  output logic               flush_id,
`ifdef IF_PERF_CNT_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles,
`endif
  output logic [1:0]         fetch_state
);
  import cpu_pkg::*;

  fetch_state_e    state_d, state_q;
  logic [PC_W-1:0] pc_d, pc_q;
  logic [PC_W-1:0] pc_inc;
  ifid_op_e        ifid_op;

  assign pc_inc = pc_q + PC_W'(1);

  // Priority: redirect > stall > memory wait > normal fetch.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ifid_op = IFID_HOLD;
    if (br_taken) begin
      pc_d    = br_target;
      ifid_op = IFID_BUBBLE;
      state_d = ST_REDIR;
    end else if (stall) begin
      ifid_op = IFID_HOLD;
    end else if (!imem_rdy) begin
      ifid_op = IFID_BUBBLE;
      state_d = ST_MISS;
    end else begin
      pc_d    = pc_inc;
      ifid_op = IFID_LOAD;
      state_d = ST_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state_q <= ST_BOOT;
      pc_q    <= PC_W'(RESET_PC);
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

  if_id_reg #(
    .INSTR_W (INSTR_W),
    .PC_W    (PC_W)
  ) u_if_id_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .op        (ifid_op),
    .instr_in  (imem_data),
    .pc_in     (pc_inc),
    .instr_out (instruction_id),
    .pc_out    (pc_id),
    .flush_out (flush_id)
  );

  assign imem_addr   = pc_q;
  assign fetch_state = state_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched_d, perf_fetched_q;
  logic [31:0] perf_bubbles_d, perf_bubbles_q;

  always_comb begin
    perf_fetched_d = perf_fetched_q;
    perf_bubbles_d = perf_bubbles_q;
    if (ifid_op == IFID_LOAD && perf_fetched_q != '1) begin
      perf_fetched_d = perf_fetched_q + 32'd1;
    end
    if (ifid_op == IFID_BUBBLE && perf_bubbles_q != '1) begin
      perf_bubbles_d = perf_bubbles_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      perf_fetched_q <= '0;
      perf_bubbles_q <= '0;
    end else begin
      perf_fetched_q <= perf_fetched_d;
      perf_bubbles_q <= perf_bubbles_d;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: 16-bit PC instance plus a 4-bit PC instance for wrap.
module tb_instr_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_rdy, stall, br_taken;
  logic [15:0] br_target;
  logic [15:0] imem_addr, pc_id;
  logic [31:0] imem_data, instruction_id;
  logic        flush_id;
  logic [1:0]  fetch_state;

  logic        br4;
  logic [3:0]  br_target4, imem_addr4, pc_id4;
  logic [31:0] imem_data4, instruction_id4;
  logic        flush_id4;
  logic [1:0]  fetch_state4;

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_bubbles, perf_fetched4, perf_bubbles4;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: word at address A is 0x80000000 | A, always ready unless imem_rdy drops.
  assign imem_data  = 32'h8000_0000 | 32'(imem_addr);
  assign imem_data4 = 32'h8000_0000 | 32'(imem_addr4);

  instr_fetch_stage #(.PC_W(16), .RESET_PC(0), .INSTR_W(32)) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_rdy       (imem_rdy),
    .stall          (stall),
    .br_taken       (br_taken),
    .br_target      (br_target),
    .instruction_id (instruction_id),
    .pc_id          (pc_id),
    .flush_id       (flush_id),
`ifdef IF_PERF_CNT_EN
    .perf_fetched   (perf_fetched),
    .perf_bubbles   (perf_bubbles),
`endif
    .fetch_state    (fetch_state)
  );

  instr_fetch_stage #(.PC_W(4), .RESET_PC(0), .INSTR_W(32)) u_dut4 (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr4),
    .imem_data      (imem_data4),
    .imem_rdy       (1'b1),
    .stall          (1'b0),
    .br_taken       (br4),
    .br_target      (br_target4),
    .instruction_id (instruction_id4),
    .pc_id          (pc_id4),
    .flush_id       (flush_id4),
`ifdef IF_PERF_CNT_EN
    .perf_fetched   (perf_fetched4),
    .perf_bubbles   (perf_bubbles4),
`endif
    .fetch_state    (fetch_state4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic chk_if(input string tag, input logic [31:0] instr, input logic [31:0] pcid,
                        input logic fl, input logic [31:0] addr, input logic [1:0] st);
    chk({tag, ".instr"}, instruction_id, instr);
    chk({tag, ".pc_id"}, 32'(pc_id), pcid);
    chk({tag, ".flush"}, 32'(flush_id), 32'(fl));
    chk({tag, ".addr"}, 32'(imem_addr), addr);
    chk({tag, ".state"}, 32'(fetch_state), 32'(st));
  endtask

  initial begin
    rst_n = 1'b1; imem_rdy = 1'b1; stall = 1'b0; br_taken = 1'b0; br_target = '0;
    br4 = 1'b0; br_target4 = '0;
    tick(); tick();
    chk_if("reset", 32'h0, 32'h0, 1'b1, 32'h0, 2'd0);
`ifdef IF_PERF_CNT_EN
    chk("reset.perf_fetched", perf_fetched, 32'd0);
    chk("reset.perf_bubbles", perf_bubbles, 32'd0);
`endif

    // First fetches after reset release
    rst_n = 1'b0;
    tick();
    chk_if("fetch0", 32'h8000_0000, 32'd1, 1'b0, 32'd1, 2'd1);
    tick();
    chk_if("fetch1", 32'h8000_0001, 32'd2, 1'b0, 32'd2, 2'd1);
    tick(); tick(); tick();
    chk_if("fetch4", 32'h8000_0004, 32'd5, 1'b0, 32'd5, 2'd1);

    // Stall three cycles at pc=5; ready data must be ignored
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_if("stall", 32'h8000_0004, 32'd5, 1'b0, 32'd5, 2'd1);
    end
    stall = 1'b0;
    tick();
    chk_if("resume", 32'h8000_0005, 32'd6, 1'b0, 32'd6, 2'd1);

    // Redirect wins over a simultaneous stall
    br_taken = 1'b1; br_target = 16'h0040; stall = 1'b1;
    tick();
    chk_if("redir", 32'h0, 32'd6, 1'b1, 32'h40, 2'd3);
    br_taken = 1'b0; stall = 1'b0;
    tick();
    chk_if("redir_fetch", 32'h8000_0040, 32'h41, 1'b0, 32'h41, 2'd1);

    // Move to pc=9, then two memory wait states
    br_taken = 1'b1; br_target = 16'd9;
    tick();
    chk("to9.addr", 32'(imem_addr), 32'd9);
    br_taken = 1'b0; imem_rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_if("miss", 32'h0, 32'h41, 1'b1, 32'd9, 2'd2);
    end
    imem_rdy = 1'b1;
    tick();
    chk_if("miss_fetch", 32'h8000_0009, 32'd10, 1'b0, 32'd10, 2'd1);

    // PC wrap on the 4-bit instance
    br4 = 1'b1; br_target4 = 4'hF;
    tick();
    chk("wrap.redir_addr", 32'(imem_addr4), 32'd15);
    chk("wrap.redir_state", 32'(fetch_state4), 32'd3);
    br4 = 1'b0;
    tick();
    chk("wrap.pc_id", 32'(pc_id4), 32'd0);
    chk("wrap.addr", 32'(imem_addr4), 32'd0);
    chk("wrap.instr", instruction_id4, 32'h8000_000F);
    chk("wrap.flush", 32'(flush_id4), 32'd0);

`ifdef IF_PERF_CNT_EN
    chk("perf_bubbles.mid", perf_bubbles, 32'd4);
`endif

    // Reset beats a simultaneous branch while running
    chk("pre_rst.state", 32'(fetch_state), 32'd1);
    rst_n = 1'b1; br_taken = 1'b1; br_target = 16'h0077;
    tick();
    chk_if("rst_br", 32'h0, 32'h0, 1'b1, 32'h0, 2'd0);
`ifdef IF_PERF_CNT_EN
    chk("rst_br.perf_fetched", perf_fetched, 32'd0);
    chk("rst_br.perf_bubbles", perf_bubbles, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
